dm_xfer_engine: RTL and testbench
=================================

// Module: dm_xfer_engine
// PURPOSE
// - Initiator-side block move engine that drives the dat_mem port (addr / dat_in / wr_en, dat_out back).
// - Issues combinational reads and clocked writes to perform COPY (src->dst) or FILL (constant->dst) of N bytes.
// - Sits beside the core's load/store path. The top-level mux hands it the memory port while busy=1.
// PARAMETERS
// - AW  8  address width; 256-byte space, all pointers wrap mod 2**AW
// - DW  8  data width of memory words
// PORTS
// - clk         in   1     single clock; all state changes on posedge
// - reset       in   1     synchronous, active-high
// - start       in   1     request; sampled only in IDLE
// - mode        in   1     0=COPY, 1=FILL (xfer_mode_t)
// - src_addr    in   AW    COPY source base
// - dst_addr    in   AW    destination base
// - len         in   AW+1  byte count 0..256
// - fill_val    in   DW    FILL data
// - busy        out  1     high from the cycle after accept through the DONE cycle
// - done        out  1     one-cycle pulse at completion
// - dm_addr     out  AW    to dat_mem addr
// - dm_dat_in   out  DW    to dat_mem dat_in
// - dm_wr_en    out  1     to dat_mem wr_en
// - dm_dat_out  in   DW    from dat_mem dat_out (combinational read)
// BEHAVIOUR
// - Clock and reset: one clock; reset is synchronous and active-high.
// - Reset values: state=IDLE, busy=0, done=0; src_cur, dst_cur, remaining and rbuf all 0.
// - dm_wr_en is forced to 0 combinationally while reset=1.
// - IDLE outputs: dm_addr=0, dm_dat_in=0, dm_wr_en=0.
// - Accept: at the posedge where state=IDLE and start=1, latch src, dst, len, mode and fill_val.
//   - Next state: RD (COPY, len!=0), WR (FILL, len!=0), or DONE (len==0).
// - RD: dm_addr=src_cur, dm_wr_en=0. At the edge: rbuf<=dm_dat_out, src_cur++ (wrap), next state WR.
// - WR: dm_addr=dst_cur, dm_dat_in = rbuf (COPY) or fill_val (FILL), dm_wr_en=1.
//   - At the edge: dst_cur++ (wrap), remaining--.
//   - Next state: DONE if remaining was 1; else RD (COPY) or WR (FILL).
// - DONE: done=1, busy=1, no memory access; next state IDLE.
// - Latency from the accept edge to the done cycle:
//   - COPY: 2N cycles of RD/WR, then done.
//   - FILL: N cycles, then done.
//   - len=0: done in the first cycle after accept, with zero writes.
// - Wrap-around: pointers roll 0xFF->0x00 silently, with no error.
// - Overlap: strictly ascending, byte by byte (read then write).
//   - dst=src+1 therefore replicates mem[src] across the range. This is defined, not an error.
// - start while busy: ignored and not queued. Inputs are also ignored while busy.
// - Reset mid-transfer: next state IDLE; the write in the reset cycle is suppressed.
//   - Bytes already written remain. done does not pulse.
// STRUCTURE
// - Package dm_xfer_pkg:
//   - xfer_mode_t {COPY, FILL}
//   - xfer_state_t {IDLE, RD, WR, DONE}
//   - localparams AW_DEF=8, DW_DEF=8
// - Single module: one registered FSM plus a pointer/counter datapath, with output decode in always_comb.
// - No sub-module is required. The bench instantiates dat_mem as the memory model.
// TESTING
// - FILL dst=0x10 len=4 fill=0xA5 -> mem[0x10..0x13]=0xA5, mem[0x14] unchanged.
//   - dm_wr_en high for exactly 4 cycles; done in cycle 5 after accept.
// - Preload mem[0x20..0x22]=11,22,33; COPY src=0x20 dst=0x80 len=3 -> mem[0x80..0x82]=11,22,33.
//   - done in cycle 7 after accept; busy low the following cycle.
// - FILL dst=0xFE len=4 val=0x3C -> writes at 0xFE, 0xFF, 0x00, 0x01 in that order; mem[0x02] unchanged.
// - len=0 -> no dm_wr_en pulse; busy and done high in cycle 1 after accept, then IDLE.
// - mem[0x40]=7; COPY src=0x40 dst=0x41 len=3 -> mem[0x41..0x43]=7.
//   - A start pulse mid-transfer is ignored: exactly 3 writes occur.
// - COPY len=8; assert reset during the 3rd WR cycle -> that write is suppressed.
//   - Only 2 destination bytes change; busy=0 after the edge; done never pulses.

Source files
------------

// File: rtl/dm_xfer_pkg.sv
// Shared types and defaults for the dat_mem block move engine.
package dm_xfer_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic {COPY = 1'b0, FILL = 1'b1} xfer_mode_t;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} xfer_state_t;
endpackage

// File: rtl/dm_xfer_engine.sv
// Block move engine: COPY (read-then-write per byte) or FILL over the dat_mem port.
module dm_xfer_engine
  import dm_xfer_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  xfer_mode_t    mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_dat_in,
  output logic          dm_wr_en,
  input  logic [DW-1:0] dm_dat_out
);

  xfer_state_t   state_q, state_d;
  xfer_mode_t    mode_q;
  logic [AW-1:0] src_cur, dst_cur;
  logic [AW:0]   remaining;
  logic [DW-1:0] rbuf, fill_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) begin
        if (len == '0)        state_d = DONE;
        else if (mode == FILL) state_d = WR;
        else                   state_d = RD;
      end
      RD:   state_d = WR;
      WR: begin
        if (remaining == (AW+1)'(1)) state_d = DONE;
        else if (mode_q == FILL)     state_d = WR;
        else                         state_d = RD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointers wrap naturally at AW bits; operands are latched so inputs are ignored while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_cur   <= '0;
      dst_cur   <= '0;
      remaining <= '0;
      rbuf      <= '0;
      fill_q    <= '0;
      mode_q    <= COPY;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          src_cur   <= src_addr;
          dst_cur   <= dst_addr;
          remaining <= len;
          mode_q    <= mode;
          fill_q    <= fill_val;
        end
        RD: begin
          rbuf    <= dm_dat_out;
          src_cur <= src_cur + AW'(1);
        end
        WR: begin
          dst_cur   <= dst_cur + AW'(1);
          remaining <= remaining - (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Write enable is gated by reset so a reset landing on a WR cycle drops that write.
  always_comb begin
    dm_addr   = '0;
    dm_dat_in = '0;
    dm_wr_en  = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    case (state_q)
      RD: dm_addr = src_cur;
      WR: begin
        dm_addr   = dst_cur;
        dm_dat_in = (mode_q == FILL) ? fill_q : rbuf;
        dm_wr_en  = ~reset;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_xfer_engine.sv
// Scoreboard bench for dm_xfer_engine with an in-bench dat_mem model.
module tb_dm_xfer_engine;
  import dm_xfer_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start;
  xfer_mode_t mode;
  logic [7:0] src_addr, dst_addr, fill_val;
  logic [8:0] len;
  logic       busy, done, dm_wr_en;
  logic [7:0] dm_addr, dm_dat_in, dm_dat_out;

  logic [7:0] mem [256];

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  wr_t exp_e;
  int  tests = 0, fails = 0, wr_cnt = 0, done_cnt = 0;
  int  w0, d0;

  dm_xfer_engine #(.AW(8), .DW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .busy(busy), .done(done), .dm_addr(dm_addr), .dm_dat_in(dm_dat_in),
    .dm_wr_en(dm_wr_en), .dm_dat_out(dm_dat_out)
  );

  always #5 clk = ~clk;

  assign dm_dat_out = mem[dm_addr];
  always @(posedge clk) if (dm_wr_en) mem[dm_addr] <= dm_dat_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every observed write is matched against the next expected one.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dm_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h, required no write", dm_addr, dm_dat_in);
      end else begin
        exp_e = exp_q.pop_front();
        chk("wr_addr", 32'(dm_addr), 32'(exp_e.a));
        chk("wr_data", 32'(dm_dat_in), 32'(exp_e.d));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic launch(input xfer_mode_t m, input logic [7:0] s, input logic [7:0] d,
                        input logic [8:0] l, input logic [7:0] f);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // c0 = cycle index after accept we are currently in; exp_c = cycle where done must show.
  task automatic wait_done(input int c0, input int exp_c, input string name);
    int c = c0;
    while (!done && c < 600) begin
      step();
      c++;
    end
    chk({name, "_done_cycle"}, 32'(c), 32'(exp_c));
    chk({name, "_busy_at_done"}, 32'(busy), 32'd1);
    step();
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    reset = 1'b1; start = 1'b0; mode = COPY;
    src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
    step(); step();
    chk("rst_wr_en", 32'(dm_wr_en), 32'd0);
    reset = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(dm_addr), 32'd0);
    chk("rst_dat", 32'(dm_dat_in), 32'd0);

    // FILL 0x10 x4 with 0xA5
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i), 8'hA5);
    w0 = wr_cnt;
    launch(FILL, 8'h00, 8'h10, 9'd4, 8'hA5);
    chk("fill_busy_c1", 32'(busy), 32'd1);
    wait_done(1, 5, "fill");
    chk("fill_wr_count", 32'(wr_cnt - w0), 32'd4);
    for (int i = 0; i < 4; i++) chk("fill_mem", 32'(mem[8'h10 + i]), 32'hA5);
    chk("fill_mem_14", 32'(mem[8'h14]), 32'h14);

    // COPY 0x20 -> 0x80 x3
    mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33;
    push(8'h80, 8'h11); push(8'h81, 8'h22); push(8'h82, 8'h33);
    w0 = wr_cnt;
    launch(COPY, 8'h20, 8'h80, 9'd3, 8'h00);
    wait_done(1, 7, "copy");
    chk("copy_wr_count", 32'(wr_cnt - w0), 32'd3);
    chk("copy_mem80", 32'(mem[8'h80]), 32'h11);
    chk("copy_mem81", 32'(mem[8'h81]), 32'h22);
    chk("copy_mem82", 32'(mem[8'h82]), 32'h33);

    // FILL wrapping past 0xFF
    push(8'hFE, 8'h3C); push(8'hFF, 8'h3C); push(8'h00, 8'h3C); push(8'h01, 8'h3C);
    w0 = wr_cnt;
    launch(FILL, 8'h00, 8'hFE, 9'd4, 8'h3C);
    wait_done(1, 5, "wrap");
    chk("wrap_wr_count", 32'(wr_cnt - w0), 32'd4);
    chk("wrap_mem00", 32'(mem[8'h00]), 32'h3C);
    chk("wrap_mem02", 32'(mem[8'h02]), 32'h02);

    // len = 0
    w0 = wr_cnt;
    launch(COPY, 8'h30, 8'h60, 9'd0, 8'h00);
    chk("len0_done_c1", 32'(done), 32'd1);
    wait_done(1, 1, "len0");
    chk("len0_wr_count", 32'(wr_cnt - w0), 32'd0);

    // Overlapping copy; a start pulse while busy must be ignored
    mem[8'h40] = 8'h07;
    push(8'h41, 8'h07); push(8'h42, 8'h07); push(8'h43, 8'h07);
    w0 = wr_cnt;
    launch(COPY, 8'h40, 8'h41, 9'd3, 8'h00);
    mode = FILL; dst_addr = 8'h00; len = 9'd5; fill_val = 8'hEE; start = 1'b1;
    step(); step();
    start = 1'b0;
    wait_done(3, 7, "ovl");
    chk("ovl_wr_count", 32'(wr_cnt - w0), 32'd3);
    for (int i = 1; i < 4; i++) chk("ovl_mem", 32'(mem[8'h40 + i]), 32'h07);
    chk("ovl_mem00", 32'(mem[8'h00]), 32'h3C);

    // Reset during the 3rd WR of a len=8 copy
    for (int i = 0; i < 8; i++) mem[8'h50 + i] = 8'(8'h60 + i);
    push(8'h90, 8'h60); push(8'h91, 8'h61);
    w0 = wr_cnt; d0 = done_cnt;
    launch(COPY, 8'h50, 8'h90, 9'd8, 8'h00);
    for (int i = 0; i < 5; i++) step();
    chk("rst_mid_in_wr", 32'(dm_addr), 32'h92);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    step(); step();
    chk("rst_mid_done_cnt", 32'(done_cnt - d0), 32'd0);
    chk("rst_mid_wr_count", 32'(wr_cnt - w0), 32'd2);
    chk("rst_mid_mem90", 32'(mem[8'h90]), 32'h60);
    chk("rst_mid_mem91", 32'(mem[8'h91]), 32'h61);
    chk("rst_mid_mem92", 32'(mem[8'h92]), 32'h92);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
